spi_bus_ctrl: RTL

//  Sequences the byte-wide spi_slave shifter into bus transactions.
//  - Runs on the system clock. Frames SPI bytes into command, address and data phases.
//  - Issues single-beat read/write requests to the shared bus (arbiter/AHB master port).
//  - Loads the next transmit byte back into the shifter.

---
 rtl/spi_bus_ctrl_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_bus_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/spi_bus_ctrl_pkg.sv
// Shared types and command codes for the SPI-to-bus sequencer.
package spi_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RFETCH,
        RDATA,
        DISCARD
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for a raw pin, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            // NOTE: non-blocking so meta/sync/prev form a true three-stage shift chain.
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise =  sync & ~prev;
    assign fall = ~sync &  prev;

endmodule

// File: rtl/spi_bus_ctrl.sv
// Frames spi_slave bytes into command/address/data phases and issues single-beat
// bus requests. Define SPI_BUS_CTRL_AUTOINC_EN for auto-incrementing burst addresses.
module spi_bus_ctrl
    import spi_bus_ctrl_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              spi_rst,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic              bus_ready,
    input  logic [7:0]        bus_rdata,
    output logic              err
);

    logic              sck_lvl, sck_rise, sck_fall;
    logic              cs_n_lvl, cs_n_rise, cs_n_fall;
    logic              cs_active;
    logic              byte_done;
    logic              bus_done;
    logic [2:0]        bit_cnt;
    logic              rd_frame;
    logic [ADDR_W-1:0] next_addr;
    state_t            state;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_sck),
        .q     (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // cs_n resets high so leaving reset never looks like a frame start.
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_cs_n),
        .q     (cs_n_lvl),
        .rise  (cs_n_rise),
        .fall  (cs_n_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_lvl, sck_fall, cs_n_rise};

    assign cs_active = ~cs_n_lvl;
    assign byte_done = cs_active & sck_rise & (bit_cnt == 3'd7);
    assign bus_done  = bus_req & bus_ready;
    assign spi_rst   = reset | spi_cs_n;

`ifdef SPI_BUS_CTRL_AUTOINC_EN
    assign next_addr = bus_addr + ADDR_W'(1);
`else
    assign next_addr = bus_addr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
        end else if (!cs_active) begin
            bit_cnt <= 3'd0;
        end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_frame  <= 1'b0;
            tx_byte   <= IDLE_BYTE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= 8'h00;
            err       <= 1'b0;
        end else begin
            // NOTE: the completion here acts as a default; a new request raised
            // further down in the same cycle overrides the bus_req drop.
            if (bus_done) begin
                bus_req <= 1'b0;
                if (bus_we) bus_addr <= next_addr;
            end

            if (!cs_active) begin
                // An outstanding request is never abandoned; leave once it completes.
                if (!bus_req || bus_ready) begin
                    state   <= IDLE;
                    tx_byte <= IDLE_BYTE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_n_fall) begin
                            state <= CMD;
                            err   <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (byte_done) begin
                            rd_frame <= (rx_byte == CMD_READ);
                            state    <= (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ADDR : DISCARD;
                        end
                    end
                    ADDR: begin
                        if (byte_done) begin
                            bus_addr <= ADDR_W'(rx_byte);
                            if (rd_frame) begin
                                bus_req <= 1'b1;
                                bus_we  <= 1'b0;
                                state   <= RFETCH;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (byte_done) begin
                            if (bus_req && !bus_ready) begin
                                err <= 1'b1;
                            end else begin
                                bus_wdata <= rx_byte;
                                bus_req   <= 1'b1;
                                bus_we    <= 1'b1;
                            end
                        end
                    end
                    RFETCH: begin
                        if (bus_done) begin
                            tx_byte <= bus_rdata;
                            state   <= RDATA;
                        end else if (byte_done) begin
                            err <= 1'b1;
                        end
                    end
                    RDATA: begin
                        if (byte_done) begin
                            bus_addr <= next_addr;
                            bus_req  <= 1'b1;
                            bus_we   <= 1'b0;
                            state    <= RFETCH;
                        end
                    end
                    DISCARD: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
